yuv422_to_rgb888: RTL and testbench
===================================

# yuv422_to_rgb888

Streaming colour-space converter: the decode-side counterpart of the RGB888→YUV422 block. Accepts 4:2:2 YUV as one 16-bit luma/chroma beat per cycle and emits one RGB888 pixel per cycle. Uses valid/ready on both sides. Sits between the YUV stream source (test harness or line buffer) and any RGB consumer.

## Interface
- COEF_RV, 359: Q8 coefficient, V→R (1.402).
- COEF_GU, 88: Q8 coefficient, U→G (0.344, subtracted).
- COEF_GV, 183: Q8 coefficient, V→G (0.714, subtracted).
- COEF_BU, 454: Q8 coefficient, U→B (1.772).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  input beat accepted when i_valid && i_ready.
- i_data  in  16  {chroma[15:8], y[7:0]}; chroma is U on even beats, V on odd beats.
- i_sol  in  1  start of line; qualifies the current beat as a U (even) beat.
- o_valid  out  1  output pixel valid.
- o_ready  in  1  downstream accepts pixel when o_valid && o_ready.
- o_rgb  out  24  {R[23:16], G[15:8], B[7:0]}.
- o_err  out  1  sticky pairing error flag.

## Operation
- Pair FSM, states WAIT_U (reset) and WAIT_V.
  - WAIT_U + accepted beat: latch Y0 and U, go to WAIT_V.
  - WAIT_V + accepted beat without i_sol: launch pixel0 (Y0,U,V=i_data[15:8]) into the math pipe this cycle. Latch Y1 and V into a pending register and set pend. Go to WAIT_U.
  - The next enabled cycle launches pixel1 (Y1,U,V) from pending and clears pend.
- A beat with i_sol in WAIT_V: discard the held half-pair, set o_err, treat the beat as a U beat, stay in WAIT_V. i_sol in WAIT_U is normal.
- o_err clears only on rst.
- Math, per pixel:
  - du=U−128, dv=V−128, both 9-bit signed.
  - R = Y + ((COEF_RV·dv + 128) >>> 8)
  - G = Y + ((−COEF_GU·du − COEF_GV·dv + 128) >>> 8)
  - B = Y + ((COEF_BU·du + 128) >>> 8)
  - Products are 18-bit signed; sums are computed at ≥20-bit signed. >>> is arithmetic (floor).
  - Each channel is clamped to [0,255].
- Pipe enable: en = !o_valid || o_ready. All pipeline registers, FSM, pending and latches update only when en.
- i_ready = en. A beat never arrives while pend is set, because a U beat launches nothing.
- Reset values: o_valid=0, o_rgb=0, o_err=0, FSM=WAIT_U, pend=0, internal valids=0. Reset mid-pair drops the half-pair silently; o_err is not set.

## Timing
- Two register stages: stage1 registers the products plus Y; stage2 registers the clamped sums into o_rgb/o_valid.
- Latency: V beat accepted in cycle t → pixel0 has o_valid in t+2, pixel1 in t+3.
- Throughput: 1 pixel/cycle sustained under back-to-back input with o_ready=1.
- Stall: when o_valid && !o_ready, o_rgb and o_valid hold stable and i_ready=0 in the same cycle (combinational from o_ready). No beat or pixel is lost or duplicated.
- Bubbles: i_valid=0 cycles insert bubbles. Pending pixel1 still launches on the next en cycle regardless of i_valid.

## Structure
- Package yuv_rgb_pkg:
  - default coefficients;
  - typedef rgb888_t as a packed struct {r,g,b};
  - typedef yuv_beat_t as a packed struct {chroma,y};
  - pair-FSM state enum.
- Sub-module yuv_pixel_to_rgb: the 2-stage math pipe with an enable input, in {y,u,v,valid} → out {rgb888_t, valid}.
- Top: pair FSM, chroma/luma latches, pending register, launch mux, handshake.

## Test plan
- Grey: beats {128,128},{128,128} → two pixels 0x808080, 0x808080; pixel0 at t+2 after the V beat.
- Clamp: Y0=255,U=128 then Y1=255,V=255 → both pixels R=255,G=164,B=255.
- Low clamp: Y=0,U=0,V=0 pair → both pixels R=0,G=136,B=0.
- Backpressure: 8-beat stream, o_ready toggles 1,0,0,1… → 8 pixels in order, o_rgb stable while stalled, i_ready low during stalls.
- Misaligned i_sol: U beat, then an i_sol beat {U'=64,Y=10}, then a V beat → o_err=1, first half-pair dropped, exactly 2 pixels built from U'=64.
- Reset mid-stream: assert rst while WAIT_V with o_valid=1 → next cycle o_valid=0, o_err=0; a following full pair converts correctly.

Source files
------------

// File: rtl/yuv_rgb_pkg.sv
// yuv_rgb_pkg: Q8 coefficients, pixel/beat structs, pair-FSM states and channel clamp shared by the YUV422->RGB888 converter
package yuv_rgb_pkg;
  localparam logic signed [17:0] COEF_RV = 18'sd359;
  localparam logic signed [17:0] COEF_GU = 18'sd88;
  localparam logic signed [17:0] COEF_GV = 18'sd183;
  localparam logic signed [17:0] COEF_BU = 18'sd454;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  typedef struct packed {
    logic [7:0] chroma;
    logic [7:0] y;
  } yuv_beat_t;
  typedef enum logic {WAIT_U, WAIT_V} pair_state_t;
  function automatic logic [7:0] clamp8(input logic signed [19:0] x);
    return x < 20'sd0 ? 8'd0 : x > 20'sd255 ? 8'd255 : x[7:0];
  endfunction
endpackage

// File: rtl/yuv_pixel_to_rgb.sv
// yuv_pixel_to_rgb: 2-stage enabled YUV->RGB math pipe (clk, rst, en, valid/y/u/v in; rgb/rgb_valid out)
module yuv_pixel_to_rgb import yuv_rgb_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       valid,
  input  logic [7:0] y,
  input  logic [7:0] u,
  input  logic [7:0] v,
  output rgb888_t    rgb,
  output logic       rgb_valid
);
  logic signed [17:0] du, dv, p_rv, p_gu, p_gv, p_bu;
  logic signed [19:0] yy, s_r, s_g, s_b;
  logic [7:0] y1;
  logic v1;
  assign du = $signed({10'd0, u}) - 18'sd128;
  assign dv = $signed({10'd0, v}) - 18'sd128;
  assign yy = $signed({12'd0, y1});
  assign s_r = p_rv + 20'sd128;
  assign s_g = 20'sd128 - p_gu - p_gv;
  assign s_b = p_bu + 20'sd128;
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      rgb_valid <= 1'b0;
      rgb <= '0;
    end else if (en) begin
      v1 <= valid;
      y1 <= y;
      p_rv <= COEF_RV * dv;
      p_gu <= COEF_GU * du;
      p_gv <= COEF_GV * dv;
      p_bu <= COEF_BU * du;
      rgb_valid <= v1;
      rgb <= '{r: clamp8(yy + (s_r >>> 8)), g: clamp8(yy + (s_g >>> 8)), b: clamp8(yy + (s_b >>> 8))};
    end
endmodule

// File: rtl/yuv422_to_rgb888.sv
// yuv422_to_rgb888: 4:2:2 beat stream (i_valid/i_ready/i_data/i_sol) to RGB888 pixel stream (o_valid/o_ready/o_rgb) with sticky pairing error o_err
module yuv422_to_rgb888 import yuv_rgb_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [15:0] i_data,
  input  logic        i_sol,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [23:0] o_rgb,
  output logic        o_err
);
  pair_state_t state, state_n;
  yuv_beat_t beat;
  rgb888_t rgb;
  logic en, acc, fire, pend, l_valid;
  logic [7:0] y0, u0, pend_y, pend_v, l_y, l_v;
  assign beat = i_data;
  assign en = !o_valid || o_ready;
  assign i_ready = en;
  assign acc = i_valid && en;
  assign fire = acc && state == WAIT_V && !i_sol;
  assign o_rgb = rgb;
  always_ff @(posedge clk)
    if (rst) state <= WAIT_U;
    else if (en) state <= state_n;
  always_comb begin
    state_n = acc && state == WAIT_U ? WAIT_V : fire ? WAIT_U : state;
    l_valid = fire || pend;
    l_y = fire ? y0 : pend_y;
    l_v = fire ? beat.chroma : pend_v;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pend <= 1'b0;
      o_err <= 1'b0;
    end else if (en) begin
      pend <= fire;
      o_err <= o_err || (acc && state == WAIT_V && i_sol);
      if (acc && !fire) {y0, u0} <= {beat.y, beat.chroma};
      if (fire) {pend_y, pend_v} <= {beat.y, beat.chroma};
    end
  yuv_pixel_to_rgb u_math (
    .clk(clk),
    .rst(rst),
    .en(en),
    .valid(l_valid),
    .y(l_y),
    .u(u0),
    .v(l_v),
    .rgb(rgb),
    .rgb_valid(o_valid)
  );
endmodule

// File: tb/tb_yuv422_to_rgb888.sv
// tb_yuv422_to_rgb888: randomized and directed self-checking bench against a pairing/arithmetic reference model
module tb_yuv422_to_rgb888;
  logic clk = 0, rst = 1, i_valid = 0, i_sol = 0, o_ready = 1;
  logic [15:0] i_data = 0;
  logic i_ready, o_valid, o_err;
  logic [23:0] o_rgb;
  int n_cmp = 0, n_bad = 0;
  logic [23:0] exp_q[$];
  bit have_u = 0, err_exp = 0, bp = 0, rnd = 0, prev_stall = 0;
  int ym, um, bp_i = 0;
  logic [23:0] prev_rgb;
  logic [3:0] pat = 4'b1001;
  yuv422_to_rgb888 dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_sol(i_sol), .o_valid(o_valid), .o_ready(o_ready), .o_rgb(o_rgb), .o_err(o_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic int fdiv256(input int a);
    return a >= 0 ? a / 256 : -((-a + 255) / 256);
  endfunction
  function automatic logic [7:0] sat(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return x[7:0];
  endfunction
  function automatic logic [23:0] ref_px(input int y, input int u, input int v);
    int du = u - 128, dv = v - 128;
    return {sat(y + fdiv256(359 * dv + 128)), sat(y + fdiv256(-88 * du - 183 * dv + 128)), sat(y + fdiv256(454 * du + 128))};
  endfunction
  function automatic void model(input logic [15:0] d, input bit sol);
    int c = int'(d[15:8]), y = int'(d[7:0]);
    if (have_u && !sol) begin
      exp_q.push_back(ref_px(ym, um, c));
      exp_q.push_back(ref_px(y, um, c));
      have_u = 0;
    end else begin
      if (have_u) err_exp = 1;
      ym = y;
      um = c;
      have_u = 1;
    end
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    o_ready = rnd ? ($urandom_range(0, 2) != 0) : bp ? pat[bp_i % 4] : 1'b1;
    if (bp) bp_i++;
  end
  always @(negedge clk)
    if (rst) prev_stall = 0;
    else begin
      chk("i_ready", i_ready, !o_valid || o_ready);
      if (prev_stall) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_rgb", o_rgb, prev_rgb);
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) chk("extra_pixel", o_valid, 0);
        else chk("pixel", o_rgb, exp_q.pop_front());
      end
      prev_stall = o_valid && !o_ready;
      prev_rgb = o_rgb;
    end
  task automatic send(input logic [15:0] d, input bit sol);
    int k = 0;
    i_valid = 1;
    i_data = d;
    i_sol = sol;
    while (!i_ready && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (!i_ready) chk("send_timeout", i_ready, 1);
    else model(d, sol);
    @(posedge clk);
    #2;
    i_valid = 0;
    i_sol = 0;
  endtask
  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("drain", exp_q.size(), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_rgb", o_rgb, 0);
    chk("rst_err", o_err, 0);
    rst = 0;
    @(posedge clk);
    #2;
    chk("rst_iready", i_ready, 1);
    send({8'd128, 8'd128}, 0);
    send({8'd128, 8'd128}, 0);
    chk("lat_t1", o_valid, 0);
    @(posedge clk);
    #2;
    chk("lat_t2", o_valid, 1);
    chk("grey0", o_rgb, 24'h808080);
    @(posedge clk);
    #2;
    chk("grey1_valid", o_valid, 1);
    chk("grey1", o_rgb, 24'h808080);
    drain();
    send({8'd128, 8'd255}, 0);
    send({8'd255, 8'd255}, 0);
    drain();
    send(16'h0000, 0);
    send(16'h0000, 0);
    drain();
    bp = 1;
    bp_i = 0;
    for (int i = 0; i < 8; i++) send(16'($urandom), 0);
    drain();
    bp = 0;
    send({8'd200, 8'd50}, 0);
    send({8'd64, 8'd10}, 1);
    send({8'd30, 8'd20}, 0);
    drain();
    chk("err_set", o_err, 1);
    send({8'd100, 8'd60}, 0);
    send({8'd150, 8'd70}, 0);
    send({8'd90, 8'd80}, 0);
    chk("pre_rst_valid", o_valid, 1);
    rst = 1;
    exp_q.delete();
    have_u = 0;
    err_exp = 0;
    @(posedge clk);
    #2;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_err", o_err, 0);
    rst = 0;
    send({8'd140, 8'd30}, 0);
    send({8'd110, 8'd200}, 0);
    drain();
    chk("post_rst_err", o_err, 0);
    rnd = 1;
    for (int i = 0; i < 300; i++)
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #2;
      end else send(16'($urandom), $urandom_range(0, 15) == 0);
    rnd = 0;
    drain();
    chk("err_final", o_err, err_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
